// File: rtl/bs_frame_sched_pkg.sv
// Shared types and constants for the bitstream frame scheduler.
// Chunk widths track W_BSDI/W_BSDIL from jpeg_global.v; the fallbacks keep this slice standalone.
`ifndef W_BSDI
`define W_BSDI 31
`endif
`ifndef W_BSDIL
`define W_BSDIL 5
`endif

package bs_frame_sched_pkg;
  localparam int DATA_W  = `W_BSDI + 1;
  localparam int LEN_W   = `W_BSDIL + 1;
  localparam int ENTRY_W = 1 + LEN_W + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_FLUSH = 3'd2,
    S_GUARD = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  typedef struct packed {
    logic              last;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } chunk_t;
endpackage

// File: rtl/bs_frame_sched_if.sv
// Encoder-side chunk handshake and packer-side load/flush signals of the frame scheduler.
// master drives chunks and frame acknowledges; slave is the scheduler itself.
interface bs_frame_sched_if;
  import bs_frame_sched_pkg::*;

  logic              ee_load_i;
  logic [DATA_W-1:0] ee_data_i;
  logic [LEN_W-1:0]  ee_len_i;
  logic              ee_last_i;
  logic              ee_ready_o;
  logic              bs_load_o;
  logic [DATA_W-1:0] bs_data_o;
  logic [LEN_W-1:0]  bs_data_len_o;
  logic              ee_frame_ready_o;
  logic              bs_frame_ready_i;

  modport master (
    output ee_load_i, ee_data_i, ee_len_i, ee_last_i, bs_frame_ready_i,
    input  ee_ready_o, bs_load_o, bs_data_o, bs_data_len_o, ee_frame_ready_o
  );

  modport slave (
    input  ee_load_i, ee_data_i, ee_len_i, ee_last_i, bs_frame_ready_i,
    output ee_ready_o, bs_load_o, bs_data_o, bs_data_len_o, ee_frame_ready_o
  );
endinterface

// File: rtl/bs_chunk_fifo.sv
// Chunk FIFO: registered storage, head entry visible at rd_data while not empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module bs_chunk_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
endmodule

// File: rtl/bs_frame_sched.sv
// Frame scheduler: replays buffered encoder chunks to the packer, issues the flush pulse,
// blocks loads for the flush window and caps frames in flight. Stats: BS_FRAME_SCHED_STATS_EN.
//  state   | meaning
//  S_IDLE  | nothing queued
//  S_RUN   | popping one chunk per cycle towards the packer
//  S_FLUSH | last chunk popped; flush pulse and pend++ on exit
//  S_GUARD | packer flush window, guard down-counter running, no pops
//  S_HOLD  | MAX_PEND frames unacknowledged, waiting for bs_frame_ready
module bs_frame_sched
  import bs_frame_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int GUARD      = 8,
  parameter int MAX_PEND   = 3
) (
  input  logic            clk,
  input  logic            rstn,
  bs_frame_sched_if.slave sched,
  output logic [2:0]      frames_pend_o,
  output logic            busy_o
`ifdef BS_FRAME_SCHED_STATS_EN
  ,
  output logic [15:0]     stat_frames_o,
  output logic [31:0]     stat_bits_o,
  output logic [31:0]     stat_last_bits_o
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = $clog2(GUARD + 1);

  state_t            state, state_nxt;
  chunk_t            wr_chunk, head;
  logic              push, pop, fifo_full, fifo_empty, pend_dec, pend_room;
  logic [CW-1:0]     fifo_count;
  logic [GW-1:0]     guard_cnt;
  logic              bs_load_q, frame_ready_q;
  logic [DATA_W-1:0] bs_data_q;
  logic [LEN_W-1:0]  bs_len_q;

  assign wr_chunk = '{last: sched.ee_last_i, len: sched.ee_len_i, data: sched.ee_data_i};
  assign push     = sched.ee_load_i & ~fifo_full;

  bs_chunk_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push),
    .wr_data (wr_chunk),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pend_dec  = sched.bs_frame_ready_i && (frames_pend_o != 3'd0);
  // An acknowledge arriving this cycle already frees a slot, so HOLD can leave without a bubble.
  assign pend_room = (frames_pend_o != 3'(MAX_PEND)) || pend_dec;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      S_IDLE:  if (!fifo_empty) state_nxt = S_RUN;
      S_RUN: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.last) state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: state_nxt = S_GUARD;
      S_GUARD: begin
        if (guard_cnt == '0) begin
          if (!pend_room)      state_nxt = S_HOLD;
          else if (fifo_empty) state_nxt = S_IDLE;
          else                 state_nxt = S_RUN;
        end
      end
      S_HOLD:  if (pend_room) state_nxt = fifo_empty ? S_IDLE : S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      guard_cnt     <= '0;
      frames_pend_o <= 3'd0;
      bs_load_q     <= 1'b0;
      bs_data_q     <= '0;
      bs_len_q      <= '0;
      frame_ready_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      frame_ready_q <= (state == S_FLUSH);
      bs_load_q     <= pop && (head.len != '0);
      if (pop) begin
        bs_data_q <= head.data;
        bs_len_q  <= head.len;
      end
      if (state == S_FLUSH)      guard_cnt <= GW'(GUARD);
      else if (guard_cnt != '0)  guard_cnt <= guard_cnt - 1'b1;
      unique case ({state == S_FLUSH, pend_dec})
        2'b10:   frames_pend_o <= frames_pend_o + 3'd1;
        2'b01:   frames_pend_o <= frames_pend_o - 3'd1;
        default: ;
      endcase
    end
  end

  assign sched.ee_ready_o       = ~fifo_full;
  assign sched.bs_load_o        = bs_load_q;
  assign sched.bs_data_o        = bs_data_q;
  assign sched.bs_data_len_o    = bs_len_q;
  assign sched.ee_frame_ready_o = frame_ready_q;
  assign busy_o = (state != S_IDLE) || (fifo_count != '0) || (frames_pend_o != 3'd0);

`ifdef BS_FRAME_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_frames_o    <= '0;
      stat_bits_o      <= '0;
      stat_last_bits_o <= '0;
    end else if (pop && head.last) begin
      stat_frames_o    <= stat_frames_o + 16'd1;
      stat_last_bits_o <= stat_bits_o + 32'(head.len);
      stat_bits_o      <= '0;
    end else if (pop) begin
      stat_bits_o      <= stat_bits_o + 32'(head.len);
    end
  end
`endif
endmodule

// File: tb/tb_bs_frame_sched.sv
// Directed bench for bs_frame_sched: load timing, guard window, HOLD, pend corner cases,
// a short random two-frame run against a chunk scoreboard, and mid-frame reset.
module tb_bs_frame_sched;
  import bs_frame_sched_pkg::*;

  localparam int GUARD = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] frames_pend;
  logic       busy;
  int         n_chk = 0;
  int         n_err = 0;
`ifdef BS_FRAME_SCHED_STATS_EN
  logic [15:0] stat_frames;
  logic [31:0] stat_bits, stat_last_bits;
`endif

  bs_frame_sched_if sif ();

  bs_frame_sched #(.FIFO_DEPTH(8), .GUARD(GUARD), .MAX_PEND(3)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .sched         (sif),
    .frames_pend_o (frames_pend),
    .busy_o        (busy)
`ifdef BS_FRAME_SCHED_STATS_EN
    ,
    .stat_frames_o    (stat_frames),
    .stat_bits_o      (stat_bits),
    .stat_last_bits_o (stat_last_bits)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l, input logic last);
    int w;
    w = 0;
    while (!sif.ee_ready_o && w < 200) begin
      tick();
      w++;
    end
    if (!sif.ee_ready_o) check("push_wait_ready", 64'(sif.ee_ready_o), 64'd1);
    sif.ee_load_i = 1'b1;
    sif.ee_data_i = d;
    sif.ee_len_i  = l;
    sif.ee_last_i = last;
    tick();
    sif.ee_load_i = 1'b0;
    sif.ee_last_i = 1'b0;
  endtask

  task automatic ack();
    sif.bs_frame_ready_i = 1'b1;
    tick();
    sif.bs_frame_ready_i = 1'b0;
  endtask

  task automatic wait_load(input string tag, input int budget);
    int w;
    w = 0;
    while (!sif.bs_load_o && w < budget) begin
      tick();
      w++;
    end
    if (!sif.bs_load_o) check(tag, 64'(sif.bs_load_o), 64'd1);
  endtask

  task automatic t6_random();
    logic [LEN_W+DATA_W-1:0] exp_q[$];
    logic [LEN_W+DATA_W-1:0] e;
    logic [LEN_W-1:0]        l;
    logic [DATA_W-1:0]       d;
    logic [63:0]             m;
    int                      n, pulses, since;
    pulses = 0;
    since  = 1000;
    fork
      begin
        for (int f = 0; f < 2; f++) begin
          n = $urandom_range(3, 6);
          for (int c = 0; c < n; c++) begin
            l = LEN_W'($urandom_range(0, DATA_W));
            m = (64'd1 << l) - 64'd1;
            d = DATA_W'($urandom) & m[DATA_W-1:0];
            if (l != '0) exp_q.push_back({l, d});
            push(d, l, c == n - 1);
            repeat ($urandom_range(0, 2)) tick();
          end
        end
      end
      begin
        for (int t = 0; t < 1000 && pulses < 2; t++) begin
          tick();
          if (sif.ee_frame_ready_o) begin
            pulses++;
            since = 0;
          end else begin
            since++;
          end
          if (sif.bs_load_o) begin
            check("t6_load_outside_flush_window", 64'(since > GUARD), 64'd1);
            if (exp_q.size() == 0) begin
              check("t6_unexpected_load", 64'(exp_q.size()), 64'd1);
            end else begin
              e = exp_q.pop_front();
              check("t6_len", 64'(sif.bs_data_len_o), 64'(e[LEN_W+DATA_W-1:DATA_W]));
              check("t6_data", 64'(sif.bs_data_o), 64'(e[DATA_W-1:0]));
            end
          end
        end
      end
    join
    check("t6_pulses", 64'(pulses), 64'd2);
    check("t6_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int nl, np;
    sif.ee_load_i        = 1'b0;
    sif.ee_data_i        = '0;
    sif.ee_len_i         = '0;
    sif.ee_last_i        = 1'b0;
    sif.bs_frame_ready_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_bs_load", 64'(sif.bs_load_o), 64'd0);
    check("rst_ee_ready", 64'(sif.ee_ready_o), 64'd1);
    check("rst_frame_ready", 64'(sif.ee_frame_ready_o), 64'd0);
    check("rst_pend", 64'(frames_pend), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rstn = 1'b1;
    tick();
    tick();

    // 1: len 5, 12, 0(last)
    push(32'h15, 6'd5, 1'b0);
    push(32'hABC, 6'd12, 1'b0);
    push(32'h0, 6'd0, 1'b1);
    check("t1_load0", 64'(sif.bs_load_o), 64'd1);
    check("t1_len0", 64'(sif.bs_data_len_o), 64'd5);
    check("t1_data0", 64'(sif.bs_data_o), 64'h15);
    tick();
    check("t1_load1", 64'(sif.bs_load_o), 64'd1);
    check("t1_len1", 64'(sif.bs_data_len_o), 64'd12);
    check("t1_data1", 64'(sif.bs_data_o), 64'hABC);
    tick();
    check("t1_zero_len_no_load", 64'(sif.bs_load_o), 64'd0);
    check("t1_no_early_flush", 64'(sif.ee_frame_ready_o), 64'd0);
    tick();
    check("t1_flush_pulse", 64'(sif.ee_frame_ready_o), 64'd1);
    check("t1_flush_no_load", 64'(sif.bs_load_o), 64'd0);
    check("t1_pend1", 64'(frames_pend), 64'd1);

    // 2: fill FIFO with next frame during the guard window
    for (int i = 0; i < 8; i++) begin
      check("t2_ready_before_push", 64'(sif.ee_ready_o), 64'd1);
      push(DATA_W'(i + 1), LEN_W'(i + 1), i == 7);
      check("t2_guard_no_load", 64'(sif.bs_load_o), 64'd0);
      check("t2_pulse_one_cycle", 64'(sif.ee_frame_ready_o), 64'd0);
    end
    check("t2_ready_low_when_full", 64'(sif.ee_ready_o), 64'd0);
    tick();
    check("t2_guard_plus1_no_load", 64'(sif.bs_load_o), 64'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_load", 64'(sif.bs_load_o), 64'd1);
      check("t2_len", 64'(sif.bs_data_len_o), 64'(i + 1));
      check("t2_data", 64'(sif.bs_data_o), 64'(i + 1));
    end
    tick();
    check("t2_flush_pulse", 64'(sif.ee_frame_ready_o), 64'd1);
    check("t2_pend2", 64'(frames_pend), 64'd2);

    // 3: third frame fills pend, fourth stalls in HOLD
    push(32'h7F, 6'd7, 1'b1);
    push(32'h1FF, 6'd9, 1'b1);
    wait_load("t3_frame3_load_timeout", 40);
    check("t3_frame3_len", 64'(sif.bs_data_len_o), 64'd7);
    tick();
    check("t3_frame3_pulse", 64'(sif.ee_frame_ready_o), 64'd1);
    check("t3_pend3", 64'(frames_pend), 64'd3);
    nl = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sif.bs_load_o) nl++;
    end
    check("t3_hold_no_load", 64'(nl), 64'd0);
    check("t3_hold_pend3", 64'(frames_pend), 64'd3);
    check("t3_hold_busy", 64'(busy), 64'd1);
    ack();
    check("t3_ack_pend2", 64'(frames_pend), 64'd2);
    check("t3_ack_cycle_no_load", 64'(sif.bs_load_o), 64'd0);
    tick();
    check("t3_resume_load", 64'(sif.bs_load_o), 64'd1);
    check("t3_resume_len", 64'(sif.bs_data_len_o), 64'd9);

    // 4: ack coincident with FLUSH, and ack with nothing pending
    ack();
    check("t4_flush_ack_pend2", 64'(frames_pend), 64'd2);
    check("t4_flush_ack_pulse", 64'(sif.ee_frame_ready_o), 64'd1);
    ack();
    check("t4_pend1", 64'(frames_pend), 64'd1);
    push(32'h3, 6'd2, 1'b1);
    wait_load("t4_frame5_load_timeout", 40);
    ack();
    check("t4_pend1_coincident", 64'(frames_pend), 64'd1);
    check("t4_pend1_pulse", 64'(sif.ee_frame_ready_o), 64'd1);
    ack();
    check("t4_pend0", 64'(frames_pend), 64'd0);
    ack();
    check("t4_no_underflow", 64'(frames_pend), 64'd0);

    // 6: random-length source, two frames, scoreboard and flush-window check
    t6_random();

    // 5: reset mid-RUN with 4 entries queued
    for (int i = 0; i < 5; i++) push(DATA_W'(4'hA + i), 6'd4, 1'b0);
    wait_load("t5_run_load_timeout", 40);
    #2;
    rstn = 1'b0;
    #1;
    check("t5_rst_load", 64'(sif.bs_load_o), 64'd0);
    check("t5_rst_data", 64'(sif.bs_data_o), 64'd0);
    check("t5_rst_len", 64'(sif.bs_data_len_o), 64'd0);
    check("t5_rst_ready", 64'(sif.ee_ready_o), 64'd1);
    check("t5_rst_pulse", 64'(sif.ee_frame_ready_o), 64'd0);
    check("t5_rst_pend", 64'(frames_pend), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    tick();
    tick();
    rstn = 1'b1;
    nl = 0;
    np = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sif.bs_load_o) nl++;
      if (sif.ee_frame_ready_o) np++;
    end
    check("t5_no_load_after_reset", 64'(nl), 64'd0);
    check("t5_no_flush_after_reset", 64'(np), 64'd0);
    check("t5_idle_after_reset", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end
endmodule
